rv_writeback_unit: RTL and testbench

Write-back stage of the uRV pipeline; the writer side of the register file. Accepts execute-stage results and pending loads, waits for data-memory load completion, aligns and sign/zero-extends load data, and drives the register-file write port plus the X-stage bypass port. Stalls the upstream pipeline while a load is outstanding.

---
 rtl/rv_defs.sv | 16 +
 rtl/rv_load_align.sv | 28 ++
 rtl/rv_writeback_unit.sv | 125 ++++++++++++
 tb/tb_rv_writeback_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_defs.sv
// Shared definitions for the uRV pipeline: load funct3 codes and
// write-back state encoding.
package rv_defs;

   localparam logic [2:0] LDST_B  = 3'b000;
   localparam logic [2:0] LDST_H  = 3'b001;
   localparam logic [2:0] LDST_W  = 3'b010;
   localparam logic [2:0] LDST_BU = 3'b100;
   localparam logic [2:0] LDST_HU = 3'b101;

   typedef enum logic {
      S_IDLE      = 1'b0,
      S_LOAD_WAIT = 1'b1
   } wb_state_t;

endpackage

// File: rtl/rv_load_align.sv
// Load data aligner: picks the byte/halfword lane addressed by the
// load and sign- or zero-extends it to 32 bits.
module rv_load_align
   import rv_defs::*;
(
   input  logic [2:0]  fun_i,
   input  logic [1:0]  addr_lsb_i,
   input  logic [31:0] data_i,
   output logic [31:0] value_o
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = data_i[8*addr_lsb_i +: 8];
      // bit 0 is not used for halfwords; misaligned loads trap earlier
      w_half = addr_lsb_i[1] ? data_i[31:16] : data_i[15:0];
      case (fun_i)
         LDST_B:  value_o = {{24{w_byte[7]}}, w_byte};
         LDST_BU: value_o = {24'h0, w_byte};
         LDST_H:  value_o = {{16{w_half[15]}}, w_half};
         LDST_HU: value_o = {16'h0, w_half};
         default: value_o = data_i;
      endcase
   end

endmodule

// File: rtl/rv_writeback_unit.sv
// uRV write-back stage: register-file writer and X-stage bypass,
// holding the pipeline while a load is outstanding.
module rv_writeback_unit
   import rv_defs::*;
#(
   parameter int g_load_timeout = 0
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        x_valid_i,
   input  logic [4:0]  x_rd_i,
   input  logic [31:0] x_rd_value_i,
   input  logic        x_rd_write_i,
   input  logic        x_load_i,
   input  logic [2:0]  x_fun_i,
   input  logic [1:0]  x_addr_lsb_i,
   input  logic [31:0] dm_data_l_i,
   input  logic        dm_load_done_i,
   output logic        w_stall_o,
   output logic [4:0]  rf_rd_o,
   output logic [31:0] rf_rd_value_o,
   output logic        rf_rd_write_o,
   output logic        rf_bypass_write_o,
   output logic [31:0] rf_bypass_value_o,
   output logic        w_load_timeout_o
);

   localparam int CW = (g_load_timeout > 0) ?
                       $clog2(g_load_timeout + 1) : 1;

   wb_state_t   r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [4:0]  r_ld_rd;
   logic [2:0]  r_ld_fun;
   logic [1:0]  r_ld_lsb;
   logic        r_ld_wr;

   logic        w_accept;
   logic        w_hit;
   logic        w_wr;
   logic        w_to;
   logic [4:0]  w_wr_rd;
   logic [31:0] w_wr_val;
   logic [31:0] w_aligned;

   rv_load_align u_align (
      .fun_i      (r_ld_fun),
      .addr_lsb_i (r_ld_lsb),
      .data_i     (dm_data_l_i),
      .value_o    (w_aligned)
   );

   assign w_stall_o = (r_state == S_LOAD_WAIT);
   assign w_accept  = x_valid_i && !w_stall_o;
   assign w_hit     = (g_load_timeout != 0) &&
                      (int'(r_cnt) == g_load_timeout - 1);

   assign rf_bypass_write_o = rf_rd_write_o;
   assign rf_bypass_value_o = rf_rd_value_o;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_wr        = 1'b0;
      w_to        = 1'b0;
      w_wr_rd     = x_rd_i;
      w_wr_val    = x_rd_value_i;
      case (r_state)
         S_IDLE: begin
            if (w_accept && x_load_i) begin
               w_state_nxt = S_LOAD_WAIT;
               w_cnt_nxt   = '0;
            end else if (w_accept) begin
               w_wr = x_rd_write_i && (x_rd_i != 5'd0);
            end
         end
         S_LOAD_WAIT: begin
            w_wr_rd  = r_ld_rd;
            w_wr_val = w_aligned;
            // completion takes priority over an expiring timeout
            if (dm_load_done_i) begin
               w_state_nxt = S_IDLE;
               w_wr        = r_ld_wr && (r_ld_rd != 5'd0);
            end else if (w_hit) begin
               w_state_nxt = S_IDLE;
               w_to        = 1'b1;
            end else if (r_cnt != '1) begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state          <= S_IDLE;
         r_cnt            <= '0;
         r_ld_rd          <= '0;
         r_ld_fun         <= '0;
         r_ld_lsb         <= '0;
         r_ld_wr          <= 1'b0;
         rf_rd_write_o    <= 1'b0;
         rf_rd_o          <= '0;
         rf_rd_value_o    <= '0;
         w_load_timeout_o <= 1'b0;
      end else begin
         r_state          <= w_state_nxt;
         r_cnt            <= w_cnt_nxt;
         rf_rd_write_o    <= w_wr;
         w_load_timeout_o <= w_to;
         if (w_wr) begin
            rf_rd_o       <= w_wr_rd;
            rf_rd_value_o <= w_wr_val;
         end
         if (w_accept && x_load_i) begin
            r_ld_rd  <= x_rd_i;
            r_ld_fun <= x_fun_i;
            r_ld_lsb <= x_addr_lsb_i;
            r_ld_wr  <= x_rd_write_i;
         end
      end
   end

endmodule

// File: tb/tb_rv_writeback_unit.sv
// Directed bench for rv_writeback_unit: ALU writes, load alignment,
// stall/back-to-back issue, timeout and mid-load reset.
module tb_rv_writeback_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        x_valid, x_rd_write, x_load;
   logic [4:0]  x_rd;
   logic [31:0] x_val;
   logic [2:0]  x_fun;
   logic [1:0]  x_lsb;
   logic [31:0] dm_data;
   logic        dm_done;
   logic        stall, rf_wr, byp_wr, tmo;
   logic [4:0]  rf_rd;
   logic [31:0] rf_val, byp_val;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   rv_writeback_unit #(.g_load_timeout(8)) dut (
      .clk_i             (clk),
      .rst_n_i           (rst_n),
      .x_valid_i         (x_valid),
      .x_rd_i            (x_rd),
      .x_rd_value_i      (x_val),
      .x_rd_write_i      (x_rd_write),
      .x_load_i          (x_load),
      .x_fun_i           (x_fun),
      .x_addr_lsb_i      (x_lsb),
      .dm_data_l_i       (dm_data),
      .dm_load_done_i    (dm_done),
      .w_stall_o         (stall),
      .rf_rd_o           (rf_rd),
      .rf_rd_value_o     (rf_val),
      .rf_rd_write_o     (rf_wr),
      .rf_bypass_write_o (byp_wr),
      .rf_bypass_value_o (byp_val),
      .w_load_timeout_o  (tmo)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_load(input logic [4:0] rd, input logic [2:0] fun,
                             input logic [1:0] lsb);
      x_valid = 1'b1; x_load = 1'b1; x_rd_write = 1'b1;
      x_rd = rd; x_fun = fun; x_lsb = lsb; x_val = 32'hDEAD0000;
      step();
      x_valid = 1'b0; x_load = 1'b0;
   endtask

   // done is also pulsed in the accept cycle, where it must be ignored
   task automatic load_case(input string tag, input logic [2:0] fun,
                            input logic [1:0] lsb, input logic [31:0] exp);
      dm_done = 1'b1; dm_data = 32'h11111111;
      issue_load(5'd9, fun, lsb);
      dm_done = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk({tag, "_stall"}, stall, 1);
         chk({tag, "_nowr"}, rf_wr, 0);
         step();
      end
      chk({tag, "_stall4"}, stall, 1);
      dm_data = 32'h80AABBCC; dm_done = 1'b1;
      step();
      dm_done = 1'b0;
      chk({tag, "_unstall"}, stall, 0);
      chk({tag, "_wr"}, rf_wr, 1);
      chk({tag, "_rd"}, rf_rd, 9);
      chk({tag, "_val"}, rf_val, exp);
      chk({tag, "_bypv"}, byp_val, exp);
      step();
      chk({tag, "_wr_end"}, rf_wr, 0);
   endtask

   initial begin
      rst_n = 1'b0; x_valid = 1'b0; x_rd_write = 1'b0; x_load = 1'b0;
      x_rd = '0; x_val = '0; x_fun = '0; x_lsb = '0;
      dm_data = '0; dm_done = 1'b0;
      #1;
      chk("rst_stall", stall, 0);
      chk("rst_wr", rf_wr, 0);
      chk("rst_byp", byp_wr, 0);
      chk("rst_rd", rf_rd, 0);
      chk("rst_val", rf_val, 0);
      chk("rst_tmo", tmo, 0);
      step(); step();
      rst_n = 1'b1;
      step();

      // ALU op rd=5
      x_valid = 1'b1; x_rd_write = 1'b1; x_rd = 5'd5; x_val = 32'h12345678;
      step();
      x_valid = 1'b0;
      chk("alu_wr", rf_wr, 1);
      chk("alu_rd", rf_rd, 5);
      chk("alu_val", rf_val, 32'h12345678);
      chk("alu_byp", byp_wr, 1);
      chk("alu_bypv", byp_val, 32'h12345678);
      step();
      chk("alu_wr_end", rf_wr, 0);
      chk("alu_byp_end", byp_wr, 0);
      chk("alu_hold", rf_val, 32'h12345678);

      // rd=0 never strobes
      x_valid = 1'b1; x_rd = 5'd0; x_val = 32'hFFFFFFFF;
      step();
      x_valid = 1'b0;
      chk("r0_wr", rf_wr, 0);
      chk("r0_byp", byp_wr, 0);
      chk("r0_rd_hold", rf_rd, 5);
      step();
      chk("r0_wr2", rf_wr, 0);

      load_case("lb", 3'b000, 2'd3, 32'hFFFFFF80);
      load_case("lbu", 3'b100, 2'd3, 32'h00000080);
      load_case("lhu", 3'b101, 2'd2, 32'h000080AA);
      load_case("lh", 3'b001, 2'd0, 32'hFFFFBBCC);
      load_case("lw", 3'b010, 2'd1, 32'h80AABBCC);

      // load then ALU rd=7 held during the stall
      issue_load(5'd9, 3'b010, 2'd0);
      x_valid = 1'b1; x_load = 1'b0; x_rd = 5'd7; x_val = 32'h1;
      for (int k = 0; k < 3; k++) begin
         chk("b2b_stall", stall, 1);
         chk("b2b_nowr", rf_wr, 0);
         step();
      end
      dm_data = 32'hCAFEF00D; dm_done = 1'b1;
      step();
      dm_done = 1'b0;
      chk("b2b_ld_wr", rf_wr, 1);
      chk("b2b_ld_rd", rf_rd, 9);
      chk("b2b_ld_val", rf_val, 32'hCAFEF00D);
      chk("b2b_ld_stall", stall, 0);
      step();
      x_valid = 1'b0;
      chk("b2b_alu_wr", rf_wr, 1);
      chk("b2b_alu_rd", rf_rd, 7);
      chk("b2b_alu_val", rf_val, 32'h1);
      step();
      chk("b2b_end", rf_wr, 0);

      // timeout after 8 stalled cycles
      issue_load(5'd10, 3'b010, 2'd0);
      for (int k = 0; k < 8; k++) begin
         chk("to_stall", stall, 1);
         chk("to_pulse_early", tmo, 0);
         step();
      end
      chk("to_pulse", tmo, 1);
      chk("to_unstall", stall, 0);
      chk("to_nowr", rf_wr, 0);
      dm_data = 32'h55555555; dm_done = 1'b1;
      step();
      dm_done = 1'b0;
      chk("to_pulse_end", tmo, 0);
      chk("late_done_wr", rf_wr, 0);
      chk("late_done_stall", stall, 0);
      step();
      chk("late_done_wr2", rf_wr, 0);

      // done coincides with the last timeout cycle: done wins
      issue_load(5'd11, 3'b010, 2'd0);
      for (int k = 0; k < 7; k++) step();
      chk("dt_stall", stall, 1);
      dm_data = 32'h0BADBEEF; dm_done = 1'b1;
      step();
      dm_done = 1'b0;
      chk("dt_wr", rf_wr, 1);
      chk("dt_rd", rf_rd, 11);
      chk("dt_val", rf_val, 32'h0BADBEEF);
      chk("dt_nopulse", tmo, 0);
      step();

      // reset in the middle of a load
      issue_load(5'd12, 3'b010, 2'd0);
      step();
      chk("mr_stall", stall, 1);
      rst_n = 1'b0;
      #1;
      chk("mr_stall0", stall, 0);
      chk("mr_rd0", rf_rd, 0);
      chk("mr_val0", rf_val, 0);
      chk("mr_wr0", rf_wr, 0);
      #2;
      rst_n = 1'b1;
      dm_data = 32'h77777777; dm_done = 1'b1;
      step();
      dm_done = 1'b0;
      chk("mr_nowr", rf_wr, 0);
      chk("mr_notmo", tmo, 0);
      chk("mr_val_keep", rf_val, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
